// File: rtl/control_pkg.sv
// Shared decode types for the MIPS main control unit.
// Holds opcode/ALUOp constants and the packed control-signal bundle.
// No logic; imported by the decoder and the registered top.
package control_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch_e;
        logic       branch_ne;
        logic       jump;
        logic [1:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/control_decode.sv
// Opcode to control-signal decoder.
// Latency: purely combinational.
// Backpressure: none; output follows the opcode input directly.
module control_decode
    import control_pkg::*;
(
    input  logic [5:0] opcode,
    output ctrl_t      ctrl,
    output logic       illegal_op
);

    always_comb begin
        ctrl       = '0;
        illegal_op = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            OP_LW: begin
                ctrl.alu_src    = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.alu_op     = ALUOP_ADD;
            end
            OP_SW: begin
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.alu_op    = ALUOP_ADD;
            end
            OP_BEQ: begin
                ctrl.branch_e = 1'b1;
                ctrl.alu_op   = ALUOP_SUB;
            end
            OP_BNE: begin
                ctrl.branch_ne = 1'b1;
                ctrl.alu_op    = ALUOP_SUB;
            end
            OP_J: begin
                ctrl.jump   = 1'b1;
                ctrl.alu_op = ALUOP_ADD;
            end
            // Unsupported opcodes decode as a NOP so the datapath stays inert.
            default: illegal_op = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Registered MIPS main control: decodes the opcode and captures it on clk.
// Latency: 1 cycle from opcode to outputs; async reset clears outputs to 0.
// Backpressure: none; a new opcode may be presented every cycle.
module control_unit
    import control_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] instruction,
    output logic       RegDst,
    output logic       ALUSrc,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       BranchE,
    output logic       BranchNE,
    output logic       Jump,
    output logic [1:0] ALUOp,
    output logic       illegal_op
);

    ctrl_t ctrl_d;
    ctrl_t ctrl_q;
    logic  illegal_d;
    logic  illegal_q;

    control_decode u_decode (
        .opcode     (instruction),
        .ctrl       (ctrl_d),
        .illegal_op (illegal_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q    <= '0;
            illegal_q <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            illegal_q <= illegal_d;
        end
    end

    assign RegDst     = ctrl_q.reg_dst;
    assign ALUSrc     = ctrl_q.alu_src;
    assign MemtoReg   = ctrl_q.mem_to_reg;
    assign RegWrite   = ctrl_q.reg_write;
    assign MemRead    = ctrl_q.mem_read;
    assign MemWrite   = ctrl_q.mem_write;
    assign BranchE    = ctrl_q.branch_e;
    assign BranchNE   = ctrl_q.branch_ne;
    assign Jump       = ctrl_q.jump;
    assign ALUOp      = ctrl_q.alu_op;
    assign illegal_op = illegal_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit with hand-computed expected output vectors.
module tb_control_unit;

    logic       clk;
    logic       rst_n;
    logic [5:0] instruction;
    logic       RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite;
    logic       BranchE, BranchNE, Jump, illegal_op;
    logic [1:0] ALUOp;

    int checks = 0;
    int errors = 0;
    int illegal_cnt;

    // {RegDst,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,BranchE,BranchNE,Jump,ALUOp,illegal_op}
    logic [11:0] outs;
    assign outs = {RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite,
                   BranchE, BranchNE, Jump, ALUOp, illegal_op};

    localparam logic [11:0] V_ZERO = 12'b0000_0000_0000;
    localparam logic [11:0] V_R    = 12'b1001_0000_0100;
    localparam logic [11:0] V_LW   = 12'b0111_1000_0000;
    localparam logic [11:0] V_SW   = 12'b0100_0100_0000;
    localparam logic [11:0] V_BEQ  = 12'b0000_0010_0010;
    localparam logic [11:0] V_BNE  = 12'b0000_0001_0010;
    localparam logic [11:0] V_J    = 12'b0000_0000_1000;
    localparam logic [11:0] V_ILL  = 12'b0000_0000_0001;

    control_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instruction(instruction),
        .RegDst     (RegDst),
        .ALUSrc     (ALUSrc),
        .MemtoReg   (MemtoReg),
        .RegWrite   (RegWrite),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .BranchE    (BranchE),
        .BranchNE   (BranchNE),
        .Jump       (Jump),
        .ALUOp      (ALUOp),
        .illegal_op (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Apply an opcode, hold it for two edges, checking after each edge.
    task automatic apply2(input string tag, input logic [5:0] op, input logic [11:0] exp);
        instruction = op;
        @(posedge clk); #1;
        check({tag, "_e1"}, outs, exp);
        @(posedge clk); #1;
        check({tag, "_e2"}, outs, exp);
    endtask

    initial begin
        rst_n       = 1'b0;
        instruction = 6'b100011;
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold", outs, V_ZERO);

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("first_edge_lw", outs, V_LW);

        apply2("rtype", 6'b000000, V_R);
        apply2("lw",    6'b100011, V_LW);
        apply2("sw",    6'b101011, V_SW);
        apply2("beq",   6'b000100, V_BEQ);
        apply2("bne",   6'b000101, V_BNE);
        apply2("j",     6'b000010, V_J);
        apply2("rtype2",6'b000000, V_R);

        apply2("ill_3f", 6'b111111, V_ILL);
        apply2("ill_08", 6'b001000, V_ILL);
        apply2("clear_ill", 6'b000100, V_BEQ);

        // Mid-cycle opcode change must not reach the outputs before an edge.
        instruction = 6'b100011;
        @(posedge clk); #1;
        check("pre_change_lw", outs, V_LW);
        #2 instruction = 6'b000010;
        #1;
        check("mid_change_hold", outs, V_LW);
        @(posedge clk); #1;
        check("post_change_j", outs, V_J);

        // Async reset with sw registered: outputs drop without a clock edge.
        instruction = 6'b101011;
        @(posedge clk); #1;
        check("sw_before_rst", outs, V_SW);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_clear", outs, V_ZERO);
        instruction = 6'b000000;
        @(posedge clk); #1;
        check("rst_low_edge", outs, V_ZERO);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("after_rst_rtype", outs, V_R);

        // Invariant sweep over every opcode.
        illegal_cnt = 0;
        for (int i = 0; i < 64; i++) begin
            instruction = 6'(i);
            @(posedge clk); #1;
            check("inv_wr_mw", {11'b0, RegWrite & MemWrite}, 12'b0);
            check("inv_br_onehot", {10'b0, 2'(int'(BranchE) + int'(BranchNE) + int'(Jump)) > 2'd1 ? 2'b01 : 2'b00}, 12'b0);
            check("inv_aluop", {11'b0, ALUOp == 2'b11}, 12'b0);
            if (illegal_op) begin
                illegal_cnt++;
                check("inv_ill_nop", outs, V_ILL);
            end
        end
        check("illegal_count", 12'(illegal_cnt), 12'd58);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
